// File: rtl/nes_pkg.sv
// Shared CPU-bus constants and the sprite-DMA state encoding.
package nes_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side bus bundle: CPU requests in, arbitrated bus out, bus read data back.
interface oam_dma_ctrl_if;

   logic [15:0] cpu_addr_i;
   logic        cpu_rw_i;
   logic [7:0]  cpu_wdata_i;
   logic [7:0]  bus_rdata_i;
   logic [15:0] bus_addr_o;
   logic        bus_rw_o;
   logic [7:0]  bus_wdata_o;

   // CPU/memory side: drives requests and read data, observes the arbitrated bus
   modport master (
      output cpu_addr_i, cpu_rw_i, cpu_wdata_i, bus_rdata_i,
      input  bus_addr_o, bus_rw_o, bus_wdata_o
   );

   modport slave (
      input  cpu_addr_i, cpu_rw_i, cpu_wdata_i, bus_rdata_i,
      output bus_addr_o, bus_rw_o, bus_wdata_o
   );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine and CPU-bus arbiter in the clk_cpu domain. A CPU write to the
// DMA register halts the CPU and copies one 256-byte page into OAMDATA.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = nes_pkg::DMA_REG_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR,
   parameter logic [8:0]  XFER_LEN     = 9'd256
) (
   input  logic          clk,
   input  logic          rst,
   oam_dma_ctrl_if.slave bus,
   output logic          cpu_halt,
   output logic          dma_active,
   output logic          dma_done
);
   import nes_pkg::*;

   dma_state_t state, state_nxt;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] latch;
   logic       put;
   logic       trigger;
   logic       last_byte;

   assign trigger   = !bus.cpu_rw_i && (bus.cpu_addr_i == DMA_REG_ADDR);
   assign last_byte = ({1'b0, idx} == XFER_LEN - 9'd1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         page     <= '0;
         idx      <= '0;
         latch    <= '0;
         put      <= 1'b0;
         dma_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         put      <= ~put;
         dma_done <= (state == WRITE) && last_byte;
         if (state == IDLE && trigger) begin
            page <= bus.cpu_wdata_i;
            idx  <= '0;
         end
         if (state == READ) latch <= bus.bus_rdata_i;
         // idx wraps inside the page; there is deliberately no carry into page
         if (state == WRITE) idx <= idx + 8'd1;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt       = state;
      bus.bus_addr_o  = bus.cpu_addr_i;
      bus.bus_rw_o    = 1'b1;
      bus.bus_wdata_o = 8'h00;
      case (state)
         IDLE: begin
            bus.bus_rw_o    = bus.cpu_rw_i;
            bus.bus_wdata_o = bus.cpu_wdata_i;
            if (trigger) state_nxt = HALT;
         end
         // put flips at this edge: put=1 now means the next cycle is an even slot
         HALT:  state_nxt = put ? READ : ALIGN;
         ALIGN: state_nxt = READ;
         READ: begin
            bus.bus_addr_o = {page, idx};
            state_nxt      = WRITE;
         end
         WRITE: begin
            bus.bus_addr_o  = OAMDATA_ADDR;
            bus.bus_rw_o    = 1'b0;
            bus.bus_wdata_o = latch;
            state_nxt       = last_byte ? IDLE : READ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cpu_halt   = (state != IDLE);
   assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: pass-through vector table plus scoreboarded
// DMA transfers covering alignment, page wrap, re-trigger and mid-transfer reset.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic cpu_halt, dma_active, dma_done;

   always #5 clk = ~clk;

   oam_dma_ctrl_if bus_if ();

   oam_dma_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .cpu_halt   (cpu_halt),
      .dma_active (dma_active),
      .dma_done   (dma_done)
   );

   int checks = 0;
   int errors = 0;

   // memory contents: page $02 holds i^$A5, other pages are additionally salted by page
   function automatic logic [7:0] ram_rd(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
   endfunction

   always_comb bus_if.bus_rdata_i = ram_rd(bus_if.bus_addr_o);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // independent model of the put parity flop
   logic tb_put;
   always @(posedge clk) begin
      if (rst) tb_put <= 1'b0;
      else     tb_put <= ~tb_put;
   end

   logic [7:0] sb_q[$];
   bit mon_en = 0;
   int halt_cycles, done_pulses, dma_writes, zero_access;

   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_halt) halt_cycles++;
         if (dma_done) begin
            done_pulses++;
            check("done_releases_bus", {30'd0, cpu_halt, dma_active}, 32'd0);
         end
         if (dma_active && bus_if.bus_addr_o == 16'h0000) zero_access++;
         if (dma_active && !bus_if.bus_rw_o) begin
            dma_writes++;
            check("dma_write_addr", {16'd0, bus_if.bus_addr_o}, 32'h2004);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got write %0h, expected no write", bus_if.bus_wdata_o);
            end else begin
               check("dma_write_data", {24'd0, bus_if.bus_wdata_o}, {24'd0, sb_q.pop_front()});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
      bus_if.cpu_addr_i  = a;
      bus_if.cpu_rw_i    = rw;
      bus_if.cpu_wdata_i = d;
   endtask

   task automatic check_mirror(input string name);
      check({name, "_addr"},  {16'd0, bus_if.bus_addr_o},  {16'd0, bus_if.cpu_addr_i});
      check({name, "_rw"},    {31'd0, bus_if.bus_rw_o},    {31'd0, bus_if.cpu_rw_i});
      check({name, "_wdata"}, {24'd0, bus_if.bus_wdata_o}, {24'd0, bus_if.cpu_wdata_i});
   endtask

   // trigger a DMA on a cycle whose put matches want_put and check the whole transfer
   task automatic run_dma(input logic [7:0] page, input logic want_put, input int exp_halt,
                          input bit retrig);
      cpu_drive(16'h8000, 1'b1, 8'h00);
      for (int k = 0; k < 4 && tb_put !== want_put; k++) step();
      halt_cycles = 0;
      done_pulses = 0;
      dma_writes  = 0;
      zero_access = 0;
      for (int i = 0; i < 256; i++) sb_q.push_back(ram_rd({page, i[7:0]}));
      cpu_drive(16'h4014, 1'b0, page);
      @(negedge clk);
      check_mirror("trigger_passthru");
      check("trigger_no_halt_yet", {31'd0, cpu_halt}, 32'd0);
      step();
      cpu_drive(16'h8000, 1'b1, 8'h00);
      for (int c = 0; c < 700 && done_pulses == 0; c++) begin
         if (retrig && c == 40) cpu_drive(16'h4014, 1'b0, 8'h03);
         if (retrig && c == 45) cpu_drive(16'h8000, 1'b1, 8'h00);
         step();
      end
      repeat (3) step();
      check("done_pulses", done_pulses, 1);
      check("halt_cycles", halt_cycles, exp_halt);
      check("write_count", dma_writes, 256);
      check("sb_drained", sb_q.size(), 0);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wdata;
      logic [15:0] exp_addr;
      logic        exp_rw;
      logic [7:0]  exp_wdata;
      logic        exp_halt;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'h2001, 1'b0, 8'h1E, 16'h2001, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{16'h2002, 1'b1, 8'h00, 16'h2002, 1'b1, 8'h00, 1'b0};
      vecs[2] = '{16'h4014, 1'b1, 8'h55, 16'h4014, 1'b1, 8'h55, 1'b0};
      vecs[3] = '{16'h0000, 1'b1, 8'h33, 16'h0000, 1'b1, 8'h33, 1'b0};
      vecs[4] = '{16'hFFFF, 1'b0, 8'hC3, 16'hFFFF, 1'b0, 8'hC3, 1'b0};
      vecs[5] = '{16'h4015, 1'b0, 8'h02, 16'h4015, 1'b0, 8'h02, 1'b0};

      rst = 1'b1;
      cpu_drive(16'h8000, 1'b1, 8'h00);
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_halt", {31'd0, cpu_halt}, 32'd0);
      check("reset_active", {31'd0, dma_active}, 32'd0);
      check("reset_done", {31'd0, dma_done}, 32'd0);
      check_mirror("reset_mirror");
      mon_en = 1;

      // pass-through vectors in IDLE
      foreach (vecs[i]) begin
         step();
         cpu_drive(vecs[i].addr, vecs[i].rw, vecs[i].wdata);
         @(negedge clk);
         check("vec_addr",  {16'd0, bus_if.bus_addr_o},  {16'd0, vecs[i].exp_addr});
         check("vec_rw",    {31'd0, bus_if.bus_rw_o},    {31'd0, vecs[i].exp_rw});
         check("vec_wdata", {24'd0, bus_if.bus_wdata_o}, {24'd0, vecs[i].exp_wdata});
         check("vec_halt",  {31'd0, cpu_halt},           {31'd0, vecs[i].exp_halt});
      end
      step();

      run_dma(8'h02, 1'b0, 513, 1'b0);   // even aligned
      run_dma(8'h02, 1'b1, 514, 1'b0);   // odd aligned, one ALIGN cycle
      run_dma(8'hFF, 1'b0, 513, 1'b0);   // page wrap
      check("no_zero_page_access", zero_access, 0);
      run_dma(8'h02, 1'b1, 514, 1'b1);   // re-trigger ignored

      // reset after 100 bytes
      cpu_drive(16'h8000, 1'b1, 8'h00);
      done_pulses = 0;
      dma_writes  = 0;
      for (int i = 0; i < 256; i++) sb_q.push_back(ram_rd({8'h02, i[7:0]}));
      cpu_drive(16'h4014, 1'b0, 8'h02);
      step();
      cpu_drive(16'h8000, 1'b1, 8'h00);
      for (int c = 0; c < 400 && dma_writes < 100; c++) step();
      check("writes_before_reset", {31'd0, dma_writes >= 100}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      cpu_drive(16'h2002, 1'b1, 8'h00);
      @(negedge clk);
      check("rst_release_halt", {31'd0, cpu_halt}, 32'd0);
      check("rst_release_active", {31'd0, dma_active}, 32'd0);
      step();
      cpu_drive(16'h2001, 1'b0, 8'h1E);
      @(negedge clk);
      check_mirror("post_rst_mirror");
      check("rst_no_done", done_pulses, 0);
      sb_q.delete();
      step();
      run_dma(8'h02, 1'b0, 513, 1'b0);   // full transfer after reset

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA engine and CPU-bus arbiter in the clk_cpu domain, placed between cpu_sim and the CPU-side bus that feeds the PPU register decode and work RAM.
- A CPU write to $4014 halts the CPU and takes ownership of the bus.
- It then copies 256 bytes from page {data,8'h00} into OAMDATA ($2004) as alternating read and write cycles.
- When idle, it passes the CPU's bus signals through unchanged.

Parameters:
- DMA_REG_ADDR, 16'h4014, address whose write triggers a DMA.
- OAMDATA_ADDR, 16'h2004, write target for every copied byte.
- XFER_LEN, 9'd256, bytes per transfer.

Ports:
- clk  in  1  CPU clock (clk_cpu).
- rst  in  1  reset; synchronous, active-high.
- cpu_addr_i  in  16  CPU address.
- cpu_rw_i  in  1  CPU read/write; 1=read.
- cpu_wdata_i  in  8  CPU write data.
- bus_rdata_i  in  8  read data returned by the bus, combinational, valid in the same cycle.
- bus_addr_o  out  16  arbitrated bus address.
- bus_rw_o  out  1  arbitrated read/write.
- bus_wdata_o  out  8  arbitrated write data.
- cpu_halt  out  1  CPU stall request; CPU holds state while high.
- dma_active  out  1  DMA owns the bus (selects DMA in the mux).
- dma_done  out  1  single-cycle pulse in the cycle after the final write.

Behaviour:
- Registers:
  - state: IDLE, HALT, ALIGN, READ, WRITE.
  - page[7:0].
  - idx[7:0].
  - latch[7:0].
  - put parity flop: toggles every clk; reset 0.
- Reset values: state=IDLE, page=0, idx=0, latch=0, put=0, cpu_halt=0, dma_active=0, dma_done=0.
- Arbitration (combinational mux):
  - IDLE: bus_* = cpu_* exactly.
  - Other states: bus_* driven by DMA.
  - HALT/ALIGN: bus_addr_o = cpu_addr_i, bus_rw_o = 1, no write.
- Trigger: in IDLE, cpu_rw_i=0 and cpu_addr_i=DMA_REG_ADDR at a clk edge causes page<=cpu_wdata_i, idx<=0, state<=HALT.
  - The triggering write itself passes through to the bus.
- HALT, one cycle: next state is READ if the next cycle has put=0, otherwise ALIGN.
- ALIGN, one cycle: next state is READ.
- READ: bus_addr_o={page,idx}, bus_rw_o=1; latch<=bus_rdata_i at the exiting edge; next state is WRITE.
- WRITE: bus_addr_o=OAMDATA_ADDR, bus_rw_o=0, bus_wdata_o=latch; idx<=idx+1.
  - Next state is IDLE if idx==XFER_LEN-1, else READ.
- Timing: with the trigger write in cycle T, cpu_halt and dma_active are high from T+1 through the final WRITE inclusive.
  - 513 cycles when T+2 has put=0.
  - 514 cycles otherwise.
  - Both deassert on the first IDLE cycle; dma_done is high in that same cycle only.
- idx is 8-bit and wraps within the page. There is no carry into page: page $FF reads $FF00-$FFFF only.
- No source-page filtering: page $20 reads PPU registers, with the side effects that implies.
- Writes to DMA_REG_ADDR outside IDLE are ignored; CPU signals are not forwarded to the bus while halted.
- rst in any state returns to IDLE at the next edge and the CPU is released. The partial transfer is abandoned without resuming, and no dma_done pulse is generated.
- A trigger and rst in the same cycle: rst wins.

Decomposition:
- Shared package nes_pkg:
  - address constants: DMA_REG_ADDR, OAMDATA_ADDR.
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
- Single module, no sub-module. The arbiter mux is a few lines and stays inline, so that state and mux select cannot diverge.

Test Plan:
- Even-aligned trigger: write $02 to $4014 in a cycle where T+2 has put=0, with a RAM model where mem[$0200+i]=i^8'hA5.
  - Expect 256 writes to $2004 with data i^$A5 in order.
  - Expect cpu_halt high for exactly 513 cycles and dma_done pulsing once.
- Odd-aligned trigger: same transfer shifted by one cycle.
  - Expect exactly one ALIGN cycle with no bus write, 514 halt cycles, and identical data sequence.
- Page wrap: page $FF.
  - Expect read addresses $FF00..$FFFF and no access to $0000; the final write is followed by IDLE.
- Re-trigger while active: a CPU write of $03 to $4014 mid-transfer while halted.
  - Expect page to stay $02, the transfer length unchanged, and no extra bus write to $4014.
- Reset mid-transfer: assert rst after 100 bytes.
  - Expect cpu_halt=0 and dma_active=0 on the next cycle, no dma_done, and bus_* equal to cpu_* in the following cycle.
  - A new trigger afterwards completes a full 256-byte transfer.
- Pass-through: IDLE, CPU writes $1E to $2001 and reads $2002.
  - Expect bus_* to mirror cpu_* in the same cycle and cpu_halt to stay 0.
